core_if_ifu: RTL and testbench

Instruction fetch unit: the transmitter side of the IF→ID valid/ready handshake that `core_id_idu`-class decode stages consume. It issues in-order word fetches to the instruction memory and buffers the returned instructions with their PCs in a small FIFO. It presents each entry to ID as `valid_out`/`o_pc`/`o_inst`/`o_branch_predict`. On a pipeline flush it redirects fetch and drops every in-flight response.

---
 rtl/core_if_ifu_pkg.sv | 41 ++++
 rtl/core_if_ibuf.sv | 50 +++++
 rtl/core_if_ifu.sv | 125 ++++++++++++
 tb/tb_core_if_ifu.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_if_ifu_pkg.sv
// Shared widths, reset PC and static branch-predictor helpers for the fetch unit.
// The width defines mirror core_defines; CORE_IFU_STATIC_BP_EN enables the static predictor in core_if_ifu.
`ifndef CORE_PC_WIDTH
`define CORE_PC_WIDTH 32
`endif
`ifndef CORE_INST_WIDTH
`define CORE_INST_WIDTH 32
`endif
`ifndef CORE_IFU_RESET_PC
`define CORE_IFU_RESET_PC `CORE_PC_WIDTH'h8000_0000
`endif

package core_if_ifu_pkg;
    localparam int PC_W = `CORE_PC_WIDTH;
    localparam int INST_W = `CORE_INST_WIDTH;
    localparam logic [PC_W-1:0] IFU_RESET_PC = `CORE_IFU_RESET_PC;

    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              predict;
    } ibuf_entry_t;

    // Backward conditional branches and all JALs are guessed taken.
    function automatic logic bp_taken(input logic [31:0] inst);
        return (inst[6:0] == OPC_JAL) || ((inst[6:0] == OPC_BRANCH) && inst[31]);
    endfunction

    function automatic logic [PC_W-1:0] bp_offset(input logic [31:0] inst);
        logic [20:0] j_imm;
        logic [12:0] b_imm;
        j_imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        b_imm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        if (inst[6:0] == OPC_JAL)
            return {{(PC_W-21){j_imm[20]}}, j_imm};
        return {{(PC_W-13){b_imm[12]}}, b_imm};
    endfunction
endpackage

// File: rtl/core_if_ibuf.sv
// Small synchronous FIFO with clear; head reads as zero while empty.
module core_if_ibuf #(
    parameter int W = 8,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] cnt,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (cnt == '0);
    assign do_pop = pop & ~empty;
    assign head   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            cnt <= cnt + CW'(push) - CW'(do_pop);
            assert (!(push && (cnt == CW'(DEPTH))));
        end
    end
endmodule

// File: rtl/core_if_ifu.sv
// Instruction fetch unit: in-order imem fetch, PC tracking, instruction buffer toward ID.
// Define CORE_IFU_STATIC_BP_EN to redirect fetch on statically predicted-taken branches.
module core_if_ifu
    import core_if_ifu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [PC_W-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_imem_req_valid,
    input  logic              i_imem_req_ready,
    output logic [PC_W-1:0]   o_imem_req_addr,
    input  logic              i_imem_rsp_valid,
    input  logic [INST_W-1:0] i_imem_rsp_inst,
    input  logic              i_pipe_flush_req,
    input  logic [PC_W-1:0]   i_flush_pc,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [PC_W-1:0]   o_pc,
    output logic [INST_W-1:0] o_inst,
    output logic              o_branch_predict
);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int TCW = $clog2(MAX_OUTSTANDING + 1);

    logic [PC_W-1:0] fetch_pc;
    logic [TCW-1:0]  out_cnt;
    logic [TCW-1:0]  drop_cnt;
    logic [FCW-1:0]  fifo_cnt;
    logic            fifo_empty;
    logic            trk_empty;
    logic [PC_W-1:0] trk_pc;
    ibuf_entry_t     fifo_in;
    ibuf_entry_t     fifo_head;
    logic            rsp_keep;
    logic            bp_predict;
    logic            bp_redirect;
    logic [PC_W-1:0] bp_target;
    logic            credit_ok;
    logic            req_fire;

`ifdef CORE_IFU_STATIC_BP_EN
    assign bp_predict = bp_taken(i_imem_rsp_inst[31:0]);
    assign bp_target  = trk_pc + bp_offset(i_imem_rsp_inst[31:0]);
`else
    assign bp_predict = 1'b0;
    assign bp_target  = trk_pc;
`endif

    assign rsp_keep    = i_imem_rsp_valid & (drop_cnt == '0) & ~i_pipe_flush_req;
    assign bp_redirect = rsp_keep & bp_predict;

    // Buffer slots already promised to live requests count against new issues.
    assign credit_ok = (32'(fifo_cnt) + 32'(out_cnt) - 32'(drop_cnt)) < 32'(FIFO_DEPTH);

    // A redirect cycle issues nothing so its drop count covers exactly the older requests.
    assign o_imem_req_valid = rst_n & ~i_pipe_flush_req & ~bp_redirect
                            & (32'(out_cnt) < 32'(MAX_OUTSTANDING)) & credit_ok;
    assign o_imem_req_addr  = fetch_pc;
    assign req_fire         = o_imem_req_valid & i_imem_req_ready;

    core_if_ibuf #(
        .W     (PC_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_track (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (i_imem_rsp_valid),
        .head      (trk_pc),
        .cnt       (out_cnt),
        .empty     (trk_empty)
    );

    assign fifo_in = '{pc: trk_pc, inst: i_imem_rsp_inst, predict: bp_predict};

    core_if_ibuf #(
        .W     ($bits(ibuf_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (i_pipe_flush_req),
        .push      (rsp_keep),
        .push_data (fifo_in),
        .pop       (valid_out & ready_out),
        .head      (fifo_head),
        .cnt       (fifo_cnt),
        .empty     (fifo_empty)
    );

    assign valid_out        = ~fifo_empty;
    assign o_pc             = fifo_head.pc;
    assign o_inst           = fifo_head.inst;
    assign o_branch_predict = fifo_head.predict;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            if (i_pipe_flush_req)
                fetch_pc <= i_flush_pc;
            else if (bp_redirect)
                fetch_pc <= bp_target;
            else if (req_fire)
                fetch_pc <= fetch_pc + PC_W'(4);

            // Every request still in flight at a redirect belongs to the abandoned path.
            if (i_pipe_flush_req)
                drop_cnt <= out_cnt - TCW'(i_imem_rsp_valid);
            else if (bp_redirect)
                drop_cnt <= out_cnt - TCW'(1);
            else if (i_imem_rsp_valid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - TCW'(1);

            assert (drop_cnt <= out_cnt);
            assert (!(i_imem_rsp_valid && trk_empty));
        end
    end
endmodule

// File: tb/tb_core_if_ifu.sv
// Randomized scoreboard bench for core_if_ifu: imem model, program model and ID-side monitor.
`timescale 1ns/1ps
module tb_core_if_ifu;
    import core_if_ifu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready = 1'b0;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid = 1'b0;
    logic [31:0] i_imem_rsp_inst = '0;
    logic        i_pipe_flush_req = 1'b0;
    logic [31:0] i_flush_pc = '0;
    logic        valid_out;
    logic        ready_out = 1'b0;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        o_branch_predict;

    core_if_ifu #(
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (RST_PC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_inst  (i_imem_rsp_inst),
        .i_pipe_flush_req (i_pipe_flush_req),
        .i_flush_pc       (i_flush_pc),
        .valid_out        (valid_out),
        .ready_out        (ready_out),
        .o_pc             (o_pc),
        .o_inst           (o_inst),
        .o_branch_predict (o_branch_predict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        bit          taken;
        int          off;
    } prog_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int n_checks = 0;
    int n_errors = 0;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];

    int cyc = 0;
    int p_req_ready = 100, p_out = 100, p_flush = 0, lat_min = 1, lat_max = 1;
    bit rst_req = 1'b0;

    bit          after_rst = 0, chk_valid_low = 0, want_first = 0;
    logic [31:0] first_addr = '0;
    int          n_acc = 0, n_pop = 0, first_val_cyc = -1;
    int          acc_cyc[$];
    logic [31:0] acc_addr_q[$];
    bit          snap_valid, snap_req_valid;
    logic [31:0] snap_pc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Program image: plain ALU ops below 0x8000_0100, a mix of jumps and branches above.
    function automatic prog_t prog(input logic [31:0] a);
        prog_t       p;
        logic [31:0] h;
        logic [31:0] o;
        int          k;
        h = (a * 32'h9E37_79B1) ^ (a >> 5);
        h = h ^ (h >> 15);
        p.taken = 1'b0;
        p.off = 4;
        p.inst = {h[31:7], 7'b0010011};
        if (a >= 32'h8000_0100) begin
            case (h[2:0])
                3'd0: begin
                    k = (int'(h[8:3]) - 16) * 4;
                    if (k == 0) k = 8;
                    o = k;
                    p.inst = {o[20], o[10:1], o[11], o[19:12], h[11:7], 7'b1101111};
                    p.taken = 1'b1;
                    p.off = k;
                end
                3'd1: begin
                    k = -(int'(h[7:3]) + 1) * 4;
                    o = k;
                    p.inst = {o[12], o[10:5], h[24:20], h[19:15], 3'b000, o[4:1], o[11], 7'b1100011};
                    p.taken = 1'b1;
                    p.off = k;
                end
                3'd2: begin
                    k = (int'(h[7:3]) + 1) * 4;
                    o = k;
                    p.inst = {o[12], o[10:5], h[24:20], h[19:15], 3'b001, o[4:1], o[11], 7'b1100011};
                end
                default: ;
            endcase
        end
        return p;
    endfunction

    // ID-side monitor: every accepted head must be the next instruction on the program path.
    always @(negedge clk) begin : mon
        logic [31:0] pc;
        prog_t       p;
        bit          pred;
        if (rst_n && valid_out && ready_out && !i_pipe_flush_req) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL id_unexpected: got pc=%h expected no entry", o_pc);
            end else begin
                pc = exp_q.pop_front();
                p = prog(pc);
`ifdef CORE_IFU_STATIC_BP_EN
                pred = p.taken;
`else
                pred = 1'b0;
`endif
                $display("ID pc=%h inst=%h bp=%0d", o_pc, o_inst, o_branch_predict);
                check("id_pc", o_pc, pc);
                check("id_inst", o_inst, p.inst);
                check("id_predict", o_branch_predict, pred);
                exp_q.push_back(pred ? pc + p.off : pc + 32'd4);
            end
        end
    end

    task automatic drive();
        prog_t p;
        rst_n = !rst_req;
        i_imem_req_ready = ($urandom_range(0, 99) < p_req_ready);
        ready_out = ($urandom_range(0, 99) < p_out);
        if (rst_n && ($urandom_range(0, 999) < p_flush)) begin
            i_pipe_flush_req = 1'b1;
            i_flush_pc = 32'h8000_0100 + 32'($urandom_range(0, 959)) * 4;
        end else begin
            i_pipe_flush_req = 1'b0;
            i_flush_pc = $urandom;
        end
        if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            p = prog(mem_q[0].addr);
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_inst = p.inst;
        end else begin
            i_imem_rsp_valid = 1'b0;
            i_imem_rsp_inst = $urandom;
        end
    endtask

    // One clock cycle: observe before the edge, update models after it, then drive new inputs.
    task automatic step();
        bit          was_rst, acc, rsp, fl;
        logic [31:0] a_addr, f_pc;
        mreq_t       m;
        @(negedge clk);
        was_rst = !rst_n;
        acc = rst_n && o_imem_req_valid && i_imem_req_ready;
        a_addr = o_imem_req_addr;
        rsp = rst_n && i_imem_rsp_valid;
        fl = rst_n && i_pipe_flush_req;
        f_pc = i_flush_pc;
        snap_valid = valid_out;
        snap_req_valid = o_imem_req_valid;
        snap_pc = o_pc;
        if (after_rst) begin
            check("rst_valid_out", valid_out, 0);
            check("rst_o_pc", o_pc, 0);
            check("rst_o_inst", o_inst, 0);
            check("rst_predict", o_branch_predict, 0);
            check("rst_req_addr", o_imem_req_addr, RST_PC);
            check("rst_req_valid", o_imem_req_valid, rst_n);
            after_rst = 0;
        end
        if (chk_valid_low) begin
            check("flush_valid_low", valid_out, 0);
            chk_valid_low = 0;
        end
        if (acc) begin
            if (want_first) begin
                check("redirect_addr", a_addr, first_addr);
                want_first = 0;
            end
            n_acc++;
            acc_cyc.push_back(cyc);
            acc_addr_q.push_back(a_addr);
        end
        if (rst_n && valid_out && first_val_cyc < 0) first_val_cyc = cyc;
        if (rst_n && valid_out && ready_out && !i_pipe_flush_req) n_pop++;
        @(posedge clk);
        #1;
        cyc++;
        if (was_rst) begin
            mem_q.delete();
            exp_q.delete();
            exp_q.push_back(RST_PC);
            want_first = 1;
            first_addr = RST_PC;
            after_rst = 1;
            n_acc = 0;
            first_val_cyc = -1;
            acc_cyc.delete();
            acc_addr_q.delete();
        end else begin
            if (rsp && mem_q.size() > 0) void'(mem_q.pop_front());
            if (acc) begin
                m.addr = a_addr;
                m.due = cyc + $urandom_range(lat_min, lat_max) - 1;
                mem_q.push_back(m);
            end
            if (fl) begin
                exp_q.delete();
                exp_q.push_back(f_pc);
                want_first = 1;
                first_addr = f_pc;
                chk_valid_low = 1;
                check("drop_cnt", dut.drop_cnt, mem_q.size());
            end
        end
        drive();
    endtask

    task automatic do_reset(input int n);
        rst_req = 1'b1;
        repeat (n) step();
        rst_req = 1'b0;
    endtask

    task automatic set_knobs(input int rr, input int po, input int pf, input int lmin, input int lmax);
        p_req_ready = rr;
        p_out = po;
        p_flush = pf;
        lat_min = lmin;
        lat_max = lmax;
    endtask

    initial begin
        int n0, k;

        // Sequential fetch at full rate after reset.
        set_knobs(100, 100, 0, 1, 1);
        do_reset(3);
        repeat (4) step();
        n_pop = 0;
        repeat (10) step();
        check("throughput_pops", n_pop, 10);
        check("acc_ge3", acc_addr_q.size() >= 3, 1);
        if (acc_addr_q.size() >= 3) begin
            check("acc0_addr", acc_addr_q[0], RST_PC);
            check("acc1_addr", acc_addr_q[1], RST_PC + 32'd4);
            check("acc2_addr", acc_addr_q[2], RST_PC + 32'd8);
            check("acc_back_to_back", acc_cyc[2] - acc_cyc[0], 2);
            check("first_valid_latency", first_val_cyc - acc_cyc[0], 2);
        end

        // ID stalled: exactly four instructions buffered, fetch stops.
        set_knobs(100, 0, 0, 1, 1);
        do_reset(1);
        repeat (12) step();
        check("stall_accepts", n_acc, 4);
        check("stall_valid", snap_valid, 1);
        check("stall_head_pc", snap_pc, RST_PC);
        check("stall_req_valid", snap_req_valid, 0);
        set_knobs(100, 100, 0, 1, 1);
        n0 = n_acc;
        k = 0;
        while (n_acc == n0 && k < 20) begin
            step();
            k++;
        end
        check("fetch_resumes", n_acc > n0, 1);
        repeat (8) step();

        // Flush with two requests outstanding.
        set_knobs(100, 100, 0, 2, 2);
        do_reset(1);
        k = 0;
        while (mem_q.size() != 2 && k < 20) begin
            step();
            k++;
        end
        check("two_outstanding", mem_q.size(), 2);
        i_pipe_flush_req = 1'b1;
        i_flush_pc = 32'h8000_0100;
        repeat (10) step();

        // Flush coinciding with a response.
        set_knobs(100, 100, 0, 1, 1);
        k = 0;
        while (!i_imem_rsp_valid && k < 20) begin
            step();
            k++;
        end
        check("rsp_for_flush", i_imem_rsp_valid, 1);
        i_pipe_flush_req = 1'b1;
        i_flush_pc = 32'h8000_0200;
        repeat (10) step();

        // Reset in the middle of traffic.
        set_knobs(100, 0, 0, 2, 3);
        repeat (6) step();
        set_knobs(100, 100, 0, 1, 2);
        do_reset(1);
        repeat (10) step();

        // Randomized traffic with flushes and occasional resets.
        n_pop = 0;
        for (int i = 0; i < 2500; i++) begin
            if (i % 100 == 0)
                set_knobs($urandom_range(30, 100), $urandom_range(20, 100),
                          $urandom_range(0, 50), 1, $urandom_range(1, 4));
            if ($urandom_range(0, 799) == 0)
                do_reset(1);
            else
                step();
        end
        check("random_progress", n_pop > 100, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
